// File: rtl/operand2_encoder.sv
// operand2_encoder: iterative inverse of the operand-2 immediate expander.
// Finds rot/imm8 (optionally of ~value) testing one candidate per cycle.
module operand2_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        allow_inv,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        inverted,
    output logic [3:0]  rot,
    output logic [7:0]  imm8,
    output logic [11:0] encoding
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  k_q;
    logic [31:0] val_q;
    logic        inv_q;
    logic        found_q;
    logic        inverted_q;
    logic [3:0]  rot_q;
    logic [7:0]  imm8_q;

    logic [31:0] operand;
    logic [3:0]  r;
    logic [5:0]  sh;
    logic [31:0] rolled;
    logic        match;
    logic        last;
    logic        accept;

    // Candidate under test: k[4] selects ~value, k[3:0] is the rotate.
    always_comb begin
        operand = k_q[4] ? ~val_q : val_q;
        r       = k_q[3:0];
        sh      = {1'b0, r, 1'b0};
        rolled  = (operand << sh) | (operand >> (6'd32 - sh));
        match   = (rolled[31:8] == 24'd0);
        last    = (k_q == 5'd31) || ((k_q == 5'd15) && !inv_q);
    end

    // Next-state: accept in IDLE, stop on first hit or last candidate.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match || last) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Capture request, step k, register result on the way into FIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q        <= 5'd0;
            val_q      <= 32'd0;
            inv_q      <= 1'b0;
            found_q    <= 1'b0;
            inverted_q <= 1'b0;
            rot_q      <= 4'd0;
            imm8_q     <= 8'd0;
        end else if (accept) begin
            k_q        <= 5'd0;
            val_q      <= value;
            inv_q      <= allow_inv;
            found_q    <= 1'b0;
            inverted_q <= 1'b0;
            rot_q      <= 4'd0;
            imm8_q     <= 8'd0;
        end else if (state_q == SEARCH) begin
            if (match) begin
                found_q    <= 1'b1;
                inverted_q <= k_q[4];
                rot_q      <= r;
                imm8_q     <= rolled[7:0];
            end else if (!last) begin
                k_q <= k_q + 5'd1;
            end
        end
    end

    assign busy     = (state_q == SEARCH);
    assign done     = (state_q == FIN);
    assign found    = found_q;
    assign inverted = inverted_q;
    assign rot      = rot_q;
    assign imm8     = imm8_q;
    assign encoding = {rot_q, imm8_q};

endmodule

// File: tb/tb_operand2_encoder.sv
// tb_operand2_encoder: directed scoreboard bench for operand2_encoder.
// Expected results are queued at request time and popped on done.
module tb_operand2_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        allow_inv;
    logic        busy;
    logic        done;
    logic        found;
    logic        inverted;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic [11:0] encoding;

    typedef struct {
        logic       found;
        logic       inv;
        logic [3:0] rot;
        logic [7:0] imm8;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    operand2_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .allow_inv(allow_inv),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .inverted (inverted),
        .rot      (rot),
        .imm8     (imm8),
        .encoding (encoding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
        chk({tag, ".found"}, {31'd0, found}, 32'd0);
        chk({tag, ".inv"}, {31'd0, inverted}, 32'd0);
        chk({tag, ".enc"}, {20'd0, encoding}, 32'd0);
    endtask

    // One request; poke=1 keeps start high with junk value during busy.
    task automatic req(input string tag, input logic [31:0] v,
                       input logic inv, input logic f, input logic ei,
                       input logic [3:0] er, input logic [7:0] eimm,
                       input int lat, input logic poke);
        exp_t e;
        exp_t got;
        int   cyc;
        logic [11:0] hold;
        e.found = f;
        e.inv   = ei;
        e.rot   = er;
        e.imm8  = eimm;
        e.lat   = lat;
        @(negedge clk);
        value     = v;
        allow_inv = inv;
        start     = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = poke;
        if (poke) value = 32'h0000_00FF;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".clr"}, {19'd0, found, encoding}, 32'd0);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        got = sb.pop_front();
        chk({tag, ".lat"}, cyc, got.lat);
        chk({tag, ".found"}, {31'd0, found}, {31'd0, got.found});
        chk({tag, ".inv"}, {31'd0, inverted}, {31'd0, got.inv});
        chk({tag, ".rot"}, {28'd0, rot}, {28'd0, got.rot});
        chk({tag, ".imm8"}, {24'd0, imm8}, {24'd0, got.imm8});
        chk({tag, ".enc"}, {20'd0, encoding},
            {20'd0, got.rot, got.imm8});
        chk({tag, ".nbusy"}, {31'd0, busy}, 32'd0);
        hold = {got.rot, got.imm8};
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".hold"}, {19'd0, found, encoding},
            {19'd0, got.found, hold});
    endtask

    initial begin
        int cyc;
        logic saw_done;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        value     = 32'd0;
        allow_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        req("ff", 32'h0000_00FF, 1'b0, 1, 0, 4'd0, 8'hFF, 1, 0);
        req("ff000000", 32'hFF00_0000, 1'b0, 1, 0, 4'd4, 8'hFF, 5, 0);
        req("f000000f", 32'hF000_000F, 1'b0, 1, 0, 4'd2, 8'hFF, 3, 1);
        req("mvn", 32'hFFFF_FF00, 1'b1, 1, 1, 4'd0, 8'hFF, 17, 0);
        req("fail16", 32'h0000_0102, 1'b0, 0, 0, 4'd0, 8'h00, 16, 1);
        req("fail32", 32'h0000_0102, 1'b1, 0, 0, 4'd0, 8'h00, 32, 1);
        req("zero", 32'h0000_0000, 1'b1, 1, 0, 4'd0, 8'h00, 1, 0);
        req("rot15", 32'h0000_03FC, 1'b0, 1, 0, 4'd15, 8'hFF, 16, 0);

        @(negedge clk);
        value     = 32'hFFFF_FF00;
        allow_inv = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst.nodone", {31'd0, saw_done}, 32'd0);
        chk_zero("midrst.held");
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        req("postrst", 32'h0000_0000, 1'b0, 1, 0, 4'd0, 8'h00, 1, 0);

        chk("sb.empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
